// File: rtl/i2c_target_responder.sv
// I2C target: 7-bit address match, byte write strobes and read byte requests via SDA open-drain enable.
// Latency: ~3 clk_i from pin edge to action; no backpressure, rd_data_i is sampled only in the rd_req_o cycle.
module i2c_target_responder #(
  parameter logic [6:0] TGT_ADDR = 7'h22
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_data_o,
  output logic       rd_req_o,
  input  logic [7:0] rd_data_i
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] rst_sync;
  logic       rst_n;
  logic [2:0] scl_q, sda_q;
  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] sh, sh_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       rw, rw_nxt;
  logic       busy_nxt, oe_nxt, start_nxt, stop_nxt, wr_valid_nxt;
  logic [7:0] wr_data_nxt;

  // Assert immediately, release synchronously to clk_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign rd_req_o  = (state == RD_LOAD);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      scl_q      <= 3'b111;
      sda_q      <= 3'b111;
      sh         <= 8'h00;
      cnt        <= 3'd0;
      rw         <= 1'b0;
      busy_o     <= 1'b0;
      sda_oe_o   <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_data_o  <= 8'h00;
    end else begin
      state      <= state_nxt;
      scl_q      <= {scl_q[1:0], scl_i};
      sda_q      <= {sda_q[1:0], sda_i};
      sh         <= sh_nxt;
      cnt        <= cnt_nxt;
      rw         <= rw_nxt;
      busy_o     <= busy_nxt;
      sda_oe_o   <= oe_nxt;
      start_o    <= start_nxt;
      stop_o     <= stop_nxt;
      wr_valid_o <= wr_valid_nxt;
      wr_data_o  <= wr_data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sh_nxt       = sh;
    cnt_nxt      = cnt;
    rw_nxt       = rw;
    busy_nxt     = busy_o;
    oe_nxt       = sda_oe_o;
    start_nxt    = 1'b0;
    stop_nxt     = 1'b0;
    wr_valid_nxt = 1'b0;
    wr_data_nxt  = wr_data_o;
    if (stop_det) begin
      stop_nxt  = 1'b1;
      busy_nxt  = 1'b0;
      oe_nxt    = 1'b0;
      state_nxt = IDLE;
      sh_nxt    = 8'h00;
      cnt_nxt   = 3'd0;
    end else if (start_det) begin
      start_nxt = 1'b1;
      oe_nxt    = 1'b0;
      state_nxt = ADDR;
      sh_nxt    = 8'h00;
      cnt_nxt   = 3'd0;
    end else begin
      case (state)
        IDLE: oe_nxt = 1'b0;
        ADDR: begin
          if (scl_rise) begin
            sh_nxt  = {sh[6:0], sda_s};
            cnt_nxt = cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (sh[6:0] == TGT_ADDR) begin
                state_nxt = ADDR_ACK;
                rw_nxt    = sda_s;
                busy_nxt  = 1'b1;
              end else begin
                state_nxt = IDLE;
              end
            end
          end
        end
        // First SCL fall starts the ACK, second ends it; a read hands over at the ACK clock's rise
        // so the first data bit can replace the ACK on the following fall.
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_o) begin
              oe_nxt = 1'b1;
            end else if (!(state == ADDR_ACK && rw)) begin
              oe_nxt    = 1'b0;
              state_nxt = WR_DATA;
            end
          end else if (scl_rise && sda_oe_o && state == ADDR_ACK && rw) begin
            state_nxt = RD_LOAD;
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            sh_nxt  = {sh[6:0], sda_s};
            cnt_nxt = cnt + 3'd1;
            if (cnt == 3'd7) begin
              wr_data_nxt  = {sh[6:0], sda_s};
              wr_valid_nxt = 1'b1;
              state_nxt    = WR_ACK;
            end
          end
        end
        RD_LOAD: begin
          sh_nxt    = rd_data_i;
          cnt_nxt   = 3'd0;
          state_nxt = RD_DATA;
        end
        RD_DATA: begin
          if (scl_fall) begin
            oe_nxt = ~sh[7];
            sh_nxt = {sh[6:0], 1'b0};
          end else if (scl_rise) begin
            cnt_nxt = cnt + 3'd1;
            if (cnt == 3'd7) state_nxt = RD_ACK;
          end
        end
        RD_ACK: begin
          if (scl_fall) begin
            oe_nxt = 1'b0;
          end else if (scl_rise) begin
            oe_nxt    = 1'b0;
            state_nxt = sda_s ? IDLE : RD_LOAD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bus-master tasks drive SCL/SDA, a scoreboard queue checks output pulses.
module tb_i2c_target_responder;
  localparam int Q = 100;
  localparam logic [1:0] EV_START = 2'd0, EV_STOP = 2'd1, EV_WR = 2'd2, EV_RD = 2'd3;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic       sda_line, sda_oe, start_p, stop_p, busy, wr_valid, rd_req;
  logic [7:0] wr_data, rd_data = 8'h00;
  int         checks = 0, failures = 0;
  logic       oe_seen = 1'b0;
  ev_t        exp_q[$];

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_responder #(.TGT_ADDR(7'h22)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .scl_i(scl), .sda_i(sda_line),
    .sda_oe_o(sda_oe), .start_o(start_p), .stop_o(stop_p), .busy_o(busy),
    .wr_valid_o(wr_valid), .wr_data_o(wr_data), .rd_req_o(rd_req), .rd_data_i(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input logic [1:0] k, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_pulse actual=kind%0d required=no_pulse", k);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", {30'd0, k}, {30'd0, e.kind});
      if (k == EV_WR) chk("sb_wr_data", {24'd0, d}, {24'd0, e.data});
    end
  endtask

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sda_oe)   oe_seen = 1'b1;
      if (start_p)  sb_check(EV_START, 8'h00);
      if (stop_p)   sb_check(EV_STOP, 8'h00);
      if (wr_valid) sb_check(EV_WR, wr_data);
      if (rd_req)   sb_check(EV_RD, 8'h00);
    end
  end

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b; #Q;
    scl = 1'b1; #Q;
    r = sda_line; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl = 1'b1; #Q;
    sda_m = 1'b1; #Q;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    acked = ~r;
  endtask

  task automatic read_byte(input logic ack, input logic [7:0] next_rd, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    rd_data = next_rd;
    bit_xfer(~ack, r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] d;
    logic [7:0] a;

    #20;
    chk("rst_sda_oe", {31'd0, sda_oe}, 0);
    chk("rst_start", {31'd0, start_p}, 0);
    chk("rst_stop", {31'd0, stop_p}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wr_valid", {31'd0, wr_valid}, 0);
    chk("rst_rd_req", {31'd0, rd_req}, 0);
    chk("rst_wr_data", {24'd0, wr_data}, 0);
    rst_n = 1'b1;
    #Q;

    // Single write of 0xA5.
    push(EV_START, 8'h00); push(EV_WR, 8'hA5); push(EV_STOP, 8'h00);
    i2c_start();
    write_byte(8'h44, ack); chk("t1_addr_ack", {31'd0, ack}, 1);
    chk("t1_busy_high", {31'd0, busy}, 1);
    write_byte(8'hA5, ack); chk("t1_data_ack", {31'd0, ack}, 1);
    i2c_stop(); #Q;
    chk("t1_busy_low", {31'd0, busy}, 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // Address mismatch.
    oe_seen = 1'b0;
    push(EV_START, 8'h00); push(EV_STOP, 8'h00);
    i2c_start();
    write_byte(8'h46, ack); chk("t2_addr_nack", {31'd0, ack}, 0);
    chk("t2_busy_low", {31'd0, busy}, 0);
    write_byte(8'h11, ack); chk("t2_data_nack", {31'd0, ack}, 0);
    i2c_stop(); #Q;
    chk("t2_oe_never", {31'd0, oe_seen}, 0);
    chk("t2_busy_after", {31'd0, busy}, 0);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Two-byte read, ACK then NACK.
    rd_data = 8'h3C;
    push(EV_START, 8'h00); push(EV_RD, 8'h00); push(EV_RD, 8'h00); push(EV_STOP, 8'h00);
    i2c_start();
    write_byte(8'h45, ack); chk("t3_addr_ack", {31'd0, ack}, 1);
    read_byte(1'b1, 8'hF0, d); chk("t3_byte0", {24'd0, d}, 32'h3C);
    read_byte(1'b0, 8'h00, d); chk("t3_byte1", {24'd0, d}, 32'hF0);
    chk("t3_oe_released", {31'd0, sda_oe}, 0);
    chk("t3_busy_until_stop", {31'd0, busy}, 1);
    i2c_stop(); #Q;
    chk("t3_busy_low", {31'd0, busy}, 0);
    chk("t3_sb_empty", exp_q.size(), 0);

    // Write 0x07, repeated START, read one byte.
    push(EV_START, 8'h00); push(EV_WR, 8'h07); push(EV_START, 8'h00); push(EV_RD, 8'h00);
    push(EV_STOP, 8'h00);
    i2c_start();
    write_byte(8'h44, ack); chk("t4_waddr_ack", {31'd0, ack}, 1);
    write_byte(8'h07, ack); chk("t4_wdata_ack", {31'd0, ack}, 1);
    rd_data = 8'h5A;
    i2c_start();
    chk("t4_busy_rs", {31'd0, busy}, 1);
    write_byte(8'h45, ack); chk("t4_raddr_ack", {31'd0, ack}, 1);
    read_byte(1'b0, 8'h00, d); chk("t4_rbyte", {24'd0, d}, 32'h5A);
    chk("t4_busy_read", {31'd0, busy}, 1);
    i2c_stop(); #Q;
    chk("t4_sb_empty", exp_q.size(), 0);

    // STOP after 4 data bits of a write.
    push(EV_START, 8'h00); push(EV_STOP, 8'h00);
    i2c_start();
    write_byte(8'h44, ack); chk("t5_addr_ack", {31'd0, ack}, 1);
    bit_xfer(1'b1, r); bit_xfer(1'b0, r); bit_xfer(1'b1, r); bit_xfer(1'b1, r);
    i2c_stop(); #Q;
    chk("t5_oe_low", {31'd0, sda_oe}, 0);
    chk("t5_busy_low", {31'd0, busy}, 0);
    chk("t5_wr_data_kept", {24'd0, wr_data}, 32'h07);
    chk("t5_sb_empty", exp_q.size(), 0);

    // Reset while the address ACK is being driven.
    push(EV_START, 8'h00);
    a = 8'h44;
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(a[i], r);
    sda_m = 1'b1; #Q;
    chk("t6_ack_driven", {31'd0, sda_oe}, 1);
    rst_n = 1'b0; #1;
    chk("t6_rst_oe", {31'd0, sda_oe}, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    chk("t6_rst_wr_data", {24'd0, wr_data}, 0);
    chk("t6_rst_pulses", {28'd0, start_p, stop_p, wr_valid, rd_req}, 0);
    #9;
    scl = 1'b1; #50;
    rst_n = 1'b1; #Q;
    chk("t6_sb_empty", exp_q.size(), 0);

    // Recovery write after reset.
    push(EV_START, 8'h00); push(EV_WR, 8'hC3); push(EV_STOP, 8'h00);
    i2c_start();
    write_byte(8'h44, ack); chk("t7_addr_ack", {31'd0, ack}, 1);
    write_byte(8'hC3, ack); chk("t7_data_ack", {31'd0, ack}, 1);
    i2c_stop(); #Q;
    chk("t7_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_target_responder.md
I2C_TARGET_RESPONDER -- requirements
Module: i2c_target_responder

Interface
REQ-001 Parameters SHALL be:
- TGT_ADDR, default 7'h22, 7-bit target address matched by the block.
REQ-002 Ports SHALL be:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- scl_i  in  1  I2C clock pin, asynchronous to clk_i.
- sda_i  in  1  I2C data pin, asynchronous to clk_i.
- sda_oe_o  out  1  1 = pull SDA low; 0 = release SDA.
- start_o  out  1  one-cycle pulse on START or repeated START.
- stop_o  out  1  one-cycle pulse on STOP.
- busy_o  out  1  high from an address match until STOP.
- wr_valid_o  out  1  one-cycle pulse: wr_data_o holds a byte written by the initiator.
- wr_data_o  out  8  last byte written by the initiator.
- rd_req_o  out  1  one-cycle pulse: the block samples rd_data_i in this cycle.
- rd_data_i  in  8  next byte to return to the initiator.

Function
REQ-003 scl_i and sda_i SHALL each pass through a 2-flop synchronizer.
REQ-004 Edge detection SHALL compare the 2nd synchronizer stage against a 3rd registered stage.
REQ-005 Condition detection:
- START = SDA falling while SCL high.
- STOP = SDA rising while SCL high.
- Each SHALL be detected in any state and SHALL override the current state in the same cycle.
REQ-006 START SHALL pulse start_o and enter ADDR with the bit counter cleared.
- A repeated START while busy SHALL behave the same way.
REQ-007 STOP SHALL:
- pulse stop_o,
- release SDA,
- clear busy_o,
- enter IDLE.
REQ-008 States SHALL be IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK.
REQ-009 Sampling: data bits SHALL be sampled on detected SCL rising edges, MSB first, into an 8-bit shift register with a 3-bit counter.
REQ-010 Driving: SDA SHALL change only on the cycle after a detected SCL falling edge.
REQ-011 ADDR, after 8 bits:
- Bits[7:1] == TGT_ADDR: go to ADDR_ACK, latch bit0 as R/W, set busy_o.
- Otherwise: go to IDLE and keep SDA released (NACK) until the next START.
REQ-012 ADDR_ACK SHALL drive SDA low from the SCL fall after bit 8 until the following SCL fall.
- Then R/W = 0: go to WR_DATA.
- Then R/W = 1: go to RD_LOAD.
REQ-013 WR_DATA, after 8 bits, SHALL:
- update wr_data_o,
- pulse wr_valid_o one cycle after the 8th SCL rise,
- go to WR_ACK.
REQ-014 WR_ACK SHALL drive ACK for one SCL period as in ADDR_ACK, then return to WR_DATA.
REQ-015 RD_LOAD SHALL:
- pulse rd_req_o for one cycle,
- capture rd_data_i into the transmit shift register in that same cycle,
- enter RD_DATA.
REQ-016 RD_DATA SHALL drive each bit, MSB first, after each SCL fall:
- bit = 0: sda_oe_o = 1.
- bit = 1: sda_oe_o = 0.
- After the 8th bit's SCL fall, SDA SHALL be released and the state SHALL be RD_ACK.
REQ-017 RD_ACK SHALL sample SDA on the SCL rise.
- 0 (ACK): go to RD_LOAD.
- 1 (NACK): go to IDLE with SDA released; busy_o stays high until STOP.
REQ-018 sda_oe_o SHALL be registered and SHALL NOT be asserted in IDLE.
REQ-019 A START or STOP that occurs mid-byte SHALL:
- abort the byte,
- discard partial shift contents,
- generate no wr_valid_o pulse.
REQ-020 rd_data_i SHALL be sampled only in the rd_req_o cycle; the user SHALL hold it valid beforehand.

Reset
REQ-021 While rst_n_i = 0 (asynchronous assert):
- state = IDLE,
- sda_oe_o = 0, start_o = 0, stop_o = 0, busy_o = 0, wr_valid_o = 0, rd_req_o = 0,
- wr_data_o = 8'h00,
- shift register and counter = 0,
- synchronizer flops = 1 (bus idle).
REQ-022 Reset deassertion SHALL be synchronized to clk_i.
- The first condition SHALL be detected no earlier than 3 cycles after release.
REQ-023 Reset asserted mid-transfer SHALL release SDA immediately; a transfer in progress is abandoned.

Verification
REQ-024 Single write:
- Stimulus: START, address 0x44 (TGT_ADDR with W), data 0xA5, STOP.
- Response: ACK on both bytes, one wr_valid_o with wr_data_o = 0xA5, start_o and stop_o each pulsed once, busy_o low after STOP.
REQ-025 Address mismatch:
- Stimulus: START, address 0x46, data 0x11, STOP.
- Response: sda_oe_o never asserted, no wr_valid_o, busy_o stays low, stop_o still pulses.
REQ-026 Read, 2 bytes:
- Stimulus: address 0x45, rd_data_i = 0x3C then 0xF0, initiator ACKs the first byte and NACKs the second.
- Response: SDA carries 0x3C then 0xF0, rd_req_o pulses exactly twice, SDA released after the NACK.
REQ-027 Write then repeated-START read:
- Stimulus: write 0x07, repeated START, address 0x45, read 1 byte, NACK, STOP.
- Response: start_o pulses twice, busy_o high throughout, wr_valid_o pulses once.
REQ-028 Mid-byte STOP:
- Stimulus: STOP after 4 data bits of a write.
- Response: no wr_valid_o, state IDLE, sda_oe_o = 0.
REQ-029 Reset during ADDR_ACK:
- Stimulus: assert rst_n_i while sda_oe_o = 1.
- Response: sda_oe_o = 0 in the same cycle and all outputs at their REQ-021 values.
